map_rom_arbiter: RTL and testbench
==================================

Name: map_rom_arbiter

Overview:
- Shares the single-read-port map ROM between three clients: the map-drawing video path and the two player collision probes (horizontal, vertical).
- The video path owns the ROM during active display, with fixed latency.
- Collision probes are served only while video is inactive (blanking), via req/gnt/rvalid and 2-way round-robin.
- Sits between draw_map, player_control, player_control_y and mape_rom in the game pipeline; replaces the multi-port ROM reads.

Parameters:
- ADDR_W, 16, ROM address width
- DATA_W, 12, ROM data width (RGB pixel)
- ROM_LAT, 1, ROM read latency in clocks (address registered in ROM to data out); range 1..3

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- vid_active  in  1  1 = video path owns ROM this cycle (active display)
- vid_addr  in  ADDR_W  video read address
- vid_rdata  out  DATA_W  video read data, fixed latency
- req_x  in  1  horizontal probe request, held until gnt_x
- addr_x  in  ADDR_W  horizontal probe address, stable while req_x=1
- gnt_x  out  1  one-cycle grant pulse
- rvalid_x  out  1  one-cycle read-data-valid pulse
- rdata_x  out  DATA_W  probe read data, meaningful only with rvalid_x
- req_y, addr_y, gnt_y, rvalid_y, rdata_y  same as the _x ports, for the vertical probe
- rom_addr  out  ADDR_W  registered address to ROM
- rom_rdata  in  DATA_W  ROM read data

Behaviour:
- Reset (rst=0, async): rom_addr=0, gnt_*=0, rvalid_*=0, busy_x=busy_y=0, tag pipeline cleared, last_grant=Y (so X wins first tie), FSM=S_IDLE.
  - No rvalid_* may be emitted for accesses issued before reset.
- rom_addr is registered every cycle. Source selected at cycle N, captured at edge N+1:
  - vid_active=1 -> vid_addr; no grant issued that cycle regardless of requests.
  - Otherwise -> address of the granted probe; if no grant, hold the previous value.
- Video latency: vid_rdata = rom_rdata, valid exactly 1+ROM_LAT cycles after vid_addr is presented with vid_active=1.
- Eligibility: client eligible when req=1 and busy=0. A busy client is masked, so a req still high in the gnt cycle is not re-granted.
- Pick (vid_active=0):
  - One eligible client -> that client.
  - Both eligible -> the client other than last_grant.
- Grant:
  - gnt_* is registered, high in cycle N+1, coincident with rom_addr update.
  - Sets busy_* and last_grant; pushes tag {x,y} into a ROM_LAT-deep shift register.
- Completion:
  - Tag reaching the end of the shift register pulses rvalid_* at N+1+ROM_LAT; rdata_* = rom_rdata that cycle.
  - busy_* clears on the same edge as rvalid_*, so the client may re-request in the rvalid cycle and be picked that cycle.
- Throughput: one grant per cycle max. X and Y may be granted back-to-back, giving pipelined rvalid_x, rvalid_y on consecutive cycles.
- vid_active rising while a probe is in flight: the probe completes normally, since the ROM is pipelined and the tag travels independently.
- FSM (for state/debug, drives the pick enable):
  - S_IDLE: no eligible client, video inactive.
  - S_SERVE: grant issued this cycle.
  - S_VIDEO: vid_active=1.
  - Transitions are evaluated each cycle from vid_active and eligibility; S_VIDEO has priority.
- Probe holding req with no blanking never times out. Clients tolerate up to one scanline of wait.

Optional Feature:
- MAP_ARB_STATS_EN defined adds three outputs:
  - cnt_x, cnt_y: 16-bit saturating grant counters.
  - max_wait: 12-bit saturating, longest req-to-gnt wait across clients.
  - All cleared by reset.
- Undefined: outputs and counters absent; core behaviour identical.

Decomposition:
- Package map_arb_pkg:
  - typedef enum client_t {CLI_X, CLI_Y}
  - typedef enum state_t {S_IDLE, S_SERVE, S_VIDEO}
  - default ROM_LAT constant
  - 16-bit counter saturation limit
- Sub-module map_arb_rr: combinational 2-way round-robin pick from {elig_x, elig_y, last_grant}, returns grant vector. Top holds all state.

Test Plan:
- Reset: hold rst=0 with req_x=1, vid_active=0 -> gnt_x, rvalid_x, rom_addr all 0. Release -> gnt_x in 2nd cycle after release.
- Video latency, ROM_LAT=1: vid_active=1, vid_addr=0x1234, ROM model returns addr[11:0] -> rom_addr=0x1234 next cycle, vid_rdata=0x234 two cycles after. req_x held high -> no gnt_x while vid_active=1.
- Round-robin: vid_active=0, req_x=req_y=1 from reset -> gnt_x cycle N+1, gnt_y cycle N+2, rvalid_x N+2, rvalid_y N+3; data matches addr_x/addr_y.
- Busy masking: req_x held high continuously -> grants spaced exactly 1+ROM_LAT cycles apart, never two before an rvalid_x.
- Blanking edge: grant X at cycle N, vid_active rises N+1 -> rvalid_x still at N+1+ROM_LAT with correct data; vid_rdata correct in the following cycles.
- Reset mid-flight: assert rst one cycle after gnt_y -> no rvalid_y ever appears. With MAP_ARB_STATS_EN, cnt_y=0 after reset.

Source files
------------

// File: rtl/map_arb_pkg.sv
// rtl/map_arb_pkg.sv - shared types and constants for the map ROM arbiter
package map_arb_pkg;

  typedef enum logic {
    CLI_X = 1'b0,
    CLI_Y = 1'b1
  } client_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_VIDEO = 2'd2
  } state_t;

  localparam int          ROM_LAT_DEF = 1;
  localparam logic [15:0] CNT_SAT     = 16'hFFFF;
  localparam logic [11:0] WAIT_SAT    = 12'hFFF;

endpackage

// File: rtl/map_rom_arbiter_if.sv
// rtl/map_rom_arbiter_if.sv - video, probe and ROM signals of the map ROM arbiter
interface map_rom_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 12
);
  logic              vid_active;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              req_x;
  logic [ADDR_W-1:0] addr_x;
  logic              gnt_x;
  logic              rvalid_x;
  logic [DATA_W-1:0] rdata_x;
  logic              req_y;
  logic [ADDR_W-1:0] addr_y;
  logic              gnt_y;
  logic              rvalid_y;
  logic [DATA_W-1:0] rdata_y;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rdata;

  modport slave (
    input  vid_active, vid_addr, req_x, addr_x, req_y, addr_y, rom_rdata,
    output vid_rdata, gnt_x, rvalid_x, rdata_x, gnt_y, rvalid_y, rdata_y, rom_addr
  );

  modport master (
    output vid_active, vid_addr, req_x, addr_x, req_y, addr_y, rom_rdata,
    input  vid_rdata, gnt_x, rvalid_x, rdata_x, gnt_y, rvalid_y, rdata_y, rom_addr
  );
endinterface

// File: rtl/map_arb_rr.sv
// rtl/map_arb_rr.sv - combinational 2-way round-robin pick, o_gnt[0]=X, o_gnt[1]=Y
module map_arb_rr
  import map_arb_pkg::*;
(
  input  logic       i_elig_x,
  input  logic       i_elig_y,
  input  client_t    i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_elig_x && i_elig_y) begin
      if (i_last == CLI_X) o_gnt[1] = 1'b1;
      else                 o_gnt[0] = 1'b1;
    end else begin
      o_gnt[0] = i_elig_x;
      o_gnt[1] = i_elig_y;
    end
  end

endmodule

// File: rtl/map_rom_arbiter.sv
// rtl/map_rom_arbiter.sv - shares the map ROM between video and two collision probes
// Optional MAP_ARB_STATS_EN adds grant counters and longest request-to-grant wait.
module map_rom_arbiter
  import map_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  map_rom_arbiter_if.slave bus,
  output state_t           o_state
`ifdef MAP_ARB_STATS_EN
  ,
  output logic [15:0]      o_cnt_x,
  output logic [15:0]      o_cnt_y,
  output logic [11:0]      o_max_wait
`endif
);

  logic                        w_elig_x;
  logic                        w_elig_y;
  logic [1:0]                  w_pick;
  logic [1:0]                  w_gnt;
  logic [1:0]                  w_done;
  logic                        w_pick_en;
  state_t                      w_state_nxt;
  logic [DATA_W-1:0]           w_rom_rdata;

  logic                        r_busy_x;
  logic                        r_busy_y;
  client_t                     r_last;
  logic [ROM_LAT-1:0][1:0]     r_tag;
  logic                        r_gnt_x;
  logic                        r_gnt_y;
  logic                        r_rvalid_x;
  logic                        r_rvalid_y;
  logic [ADDR_W-1:0]           r_rom_addr;
  state_t                      r_state;

  // A busy client is masked so a request still held in its grant cycle is not re-granted.
  assign w_elig_x = bus.req_x & ~r_busy_x;
  assign w_elig_y = bus.req_y & ~r_busy_y;

  map_arb_rr u_rr (
    .i_elig_x (w_elig_x),
    .i_elig_y (w_elig_y),
    .i_last   (r_last),
    .o_gnt    (w_pick)
  );

  always_comb begin
    w_state_nxt = S_IDLE;
    if (bus.vid_active)  w_state_nxt = S_VIDEO;
    else if (|w_pick)    w_state_nxt = S_SERVE;
  end

  assign w_pick_en = (w_state_nxt == S_SERVE);
  assign w_gnt     = w_pick_en ? w_pick : 2'b00;
  assign w_done    = r_tag[ROM_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy_x   <= 1'b0;
      r_busy_y   <= 1'b0;
      r_last     <= CLI_Y;
      r_tag      <= '0;
      r_gnt_x    <= 1'b0;
      r_gnt_y    <= 1'b0;
      r_rvalid_x <= 1'b0;
      r_rvalid_y <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_x    <= w_gnt[0];
      r_gnt_y    <= w_gnt[1];
      r_rvalid_x <= w_done[0];
      r_rvalid_y <= w_done[1];
      r_busy_x   <= (r_busy_x & ~w_done[0]) | w_gnt[0];
      r_busy_y   <= (r_busy_y & ~w_done[1]) | w_gnt[1];
      // Tags follow the ROM pipeline, so video taking over mid-flight cannot lose a probe.
      r_tag[0]   <= w_gnt;
      for (int i = 1; i < ROM_LAT; i++) r_tag[i] <= r_tag[i-1];
      if (bus.vid_active)  r_rom_addr <= bus.vid_addr;
      else if (w_gnt[0])   r_rom_addr <= bus.addr_x;
      else if (w_gnt[1])   r_rom_addr <= bus.addr_y;
      if (w_gnt[0])        r_last <= CLI_X;
      else if (w_gnt[1])   r_last <= CLI_Y;
    end
  end

  assign w_rom_rdata  = bus.rom_rdata;
  assign bus.vid_rdata = w_rom_rdata;
  assign bus.rdata_x  = w_rom_rdata;
  assign bus.rdata_y  = w_rom_rdata;
  assign bus.rom_addr = r_rom_addr;
  assign bus.gnt_x    = r_gnt_x;
  assign bus.gnt_y    = r_gnt_y;
  assign bus.rvalid_x = r_rvalid_x;
  assign bus.rvalid_y = r_rvalid_y;
  assign o_state      = r_state;

`ifdef MAP_ARB_STATS_EN
  logic [15:0] r_cnt_x;
  logic [15:0] r_cnt_y;
  logic [11:0] r_wait_x;
  logic [11:0] r_wait_y;
  logic [11:0] r_max_wait;
  logic [11:0] w_fin_x;
  logic [11:0] w_fin_y;

  // Wait includes the grant decision cycle itself.
  assign w_fin_x = (r_wait_x == WAIT_SAT) ? WAIT_SAT : r_wait_x + 12'd1;
  assign w_fin_y = (r_wait_y == WAIT_SAT) ? WAIT_SAT : r_wait_y + 12'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_x    <= '0;
      r_cnt_y    <= '0;
      r_wait_x   <= '0;
      r_wait_y   <= '0;
      r_max_wait <= '0;
    end else begin
      if (w_gnt[0] && r_cnt_x != CNT_SAT) r_cnt_x <= r_cnt_x + 16'd1;
      if (w_gnt[1] && r_cnt_y != CNT_SAT) r_cnt_y <= r_cnt_y + 16'd1;
      if (w_gnt[0])                                   r_wait_x <= '0;
      else if (bus.req_x && r_wait_x != WAIT_SAT)     r_wait_x <= r_wait_x + 12'd1;
      if (w_gnt[1])                                   r_wait_y <= '0;
      else if (bus.req_y && r_wait_y != WAIT_SAT)     r_wait_y <= r_wait_y + 12'd1;
      if (w_gnt[0] && w_fin_x > r_max_wait)           r_max_wait <= w_fin_x;
      else if (w_gnt[1] && w_fin_y > r_max_wait)      r_max_wait <= w_fin_y;
    end
  end

  assign o_cnt_x    = r_cnt_x;
  assign o_cnt_y    = r_cnt_y;
  assign o_max_wait = r_max_wait;
`endif

endmodule

// File: tb/tb_map_rom_arbiter.sv
// tb/tb_map_rom_arbiter.sv - randomized scoreboard bench for map_rom_arbiter
module tb_map_rom_arbiter;
  import map_arb_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 12;
  localparam int ROM_LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  map_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  state_t state;
`ifdef MAP_ARB_STATS_EN
  logic [15:0] cnt_x;
  logic [15:0] cnt_y;
  logic [11:0] max_wait;
`endif

  map_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (state)
`ifdef MAP_ARB_STATS_EN
    ,
    .o_cnt_x    (cnt_x),
    .o_cnt_y    (cnt_y),
    .o_max_wait (max_wait)
`endif
  );

  function automatic logic [11:0] rom_fn(input logic [15:0] a);
    return a[11:0];
  endfunction

  // ROM model: address registered, data ROM_LAT clocks later.
  logic [ADDR_W-1:0] rom_pipe [ROM_LAT] = '{default: '0};
  always @(posedge clk) begin
    rom_pipe[0] <= bus.rom_addr;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign bus.rom_rdata = rom_fn(rom_pipe[ROM_LAT-1]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic gx; logic gy; logic [15:0] ra; state_t st; } cyc_exp_t;
  typedef struct { int cyc; logic rx; logic ry; logic [11:0] d; logic vchk; logic [11:0] vd; } rd_exp_t;
  cyc_exp_t cq[$];
  rd_exp_t  rq[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Reference model state: each client is free again from its completion cycle on.
  int      done_x, done_y, k0_x, k0_y, cntx, cnty, maxw;
  client_t last;
  logic [15:0] exp_ra;
  bit pg_x, pg_y;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic reset_model();
    done_x = 0; done_y = 0; last = CLI_Y; exp_ra = '0;
    cntx = 0; cnty = 0; maxw = 0; pg_x = 0; pg_y = 0;
    k0_x = cyc; k0_y = cyc;
  endtask

  task automatic model_step();
    cyc_exp_t ce;
    rd_exp_t  re;
    logic ex, ey, gx, gy;
    int w;
    ex = bus.req_x && (cyc >= done_x);
    ey = bus.req_y && (cyc >= done_y);
    gx = 0; gy = 0;
    if (!bus.vid_active) begin
      if (ex && ey) begin
        gx = (last == CLI_Y);
        gy = (last == CLI_X);
      end else begin
        gx = ex; gy = ey;
      end
    end
    if (bus.vid_active) exp_ra = bus.vid_addr;
    else if (gx)        exp_ra = bus.addr_x;
    else if (gy)        exp_ra = bus.addr_y;
    if (gx) begin
      last = CLI_X; done_x = cyc + 1 + ROM_LAT; cntx++;
      w = cyc + 1 - k0_x; if (w > 4095) w = 4095; if (w > maxw) maxw = w;
    end
    if (gy) begin
      last = CLI_Y; done_y = cyc + 1 + ROM_LAT; cnty++;
      w = cyc + 1 - k0_y; if (w > 4095) w = 4095; if (w > maxw) maxw = w;
    end
    ce = '{cyc + 1, gx, gy, exp_ra,
           bus.vid_active ? S_VIDEO : ((gx || gy) ? S_SERVE : S_IDLE)};
    re = '{cyc + 1 + ROM_LAT, gx, gy, rom_fn(gx ? bus.addr_x : bus.addr_y),
           bus.vid_active, rom_fn(bus.vid_addr)};
    cq.push_back(ce);
    rq.push_back(re);
    pg_x = gx; pg_y = gy;
  endtask

  // mode 0: both probes always requesting, no video; 1: random; 2: video active.
  task automatic drive(input int mode, input bit first);
    if (mode == 2)      bus.vid_active = 1'b1;
    else if (mode == 0) bus.vid_active = 1'b0;
    else if ($urandom_range(7) == 0) bus.vid_active = ~bus.vid_active;
    bus.vid_addr = (mode == 2 && first) ? 16'h1234 : 16'($urandom);
    if (bus.req_x && pg_x) begin
      if (mode == 0 || $urandom_range(1) == 1) begin bus.addr_x = 16'($urandom); k0_x = cyc; end
      else bus.req_x = 1'b0;
    end else if (!bus.req_x && (mode == 0 || $urandom_range(2) == 0)) begin
      bus.req_x = 1'b1; bus.addr_x = 16'($urandom); k0_x = cyc;
    end
    if (bus.req_y && pg_y) begin
      if (mode == 0 || $urandom_range(1) == 1) begin bus.addr_y = 16'($urandom); k0_y = cyc; end
      else bus.req_y = 1'b0;
    end else if (!bus.req_y && (mode == 0 || $urandom_range(2) == 0)) begin
      bus.req_y = 1'b1; bus.addr_y = 16'($urandom); k0_y = cyc;
    end
  endtask

  always @(negedge clk) begin
    cyc_exp_t e;
    rd_exp_t  r;
    if (chk_en) begin
      if (cq.size() > 0 && cq[0].cyc == cyc) begin
        e = cq.pop_front();
        chk("gnt_x", bus.gnt_x, e.gx);
        chk("gnt_y", bus.gnt_y, e.gy);
        chk("rom_addr", bus.rom_addr, e.ra);
        chk("state", state, e.st);
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        chk("rvalid_x", bus.rvalid_x, r.rx);
        chk("rvalid_y", bus.rvalid_y, r.ry);
        if (r.rx)   chk("rdata_x", bus.rdata_x, r.d);
        if (r.ry)   chk("rdata_y", bus.rdata_y, r.d);
        if (r.vchk) chk("vid_rdata", bus.vid_rdata, r.vd);
      end
    end
  end

  task automatic run(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      drive(mode, i == 0);
      model_step();
      @(negedge clk);
    end
  endtask

  initial begin
    bit hit;
    bus.vid_active = 1'b0; bus.vid_addr = '0;
    bus.req_x = 1'b1; bus.addr_x = 16'h0ABC;
    bus.req_y = 1'b0; bus.addr_y = '0;
    rst_n = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    chk("rst_gnt_x", bus.gnt_x, 1'b0);
    chk("rst_rvalid_x", bus.rvalid_x, 1'b0);
    chk("rst_rom_addr", bus.rom_addr, 16'h0);
    chk("rst_state", state, S_IDLE);
    rst_n = 1'b1;
    reset_model();
    chk_en = 1;

    run(0, 40);
    run(2, 6);
    run(0, 10);
    run(1, 600);
    run(2, 4);
    run(1, 300);

    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (pg_y) hit = 1;
      else begin
        drive(1, 0);
        bus.vid_active = 1'b0;
        model_step();
        @(negedge clk);
      end
    end
    chk("mid_gnt_y_seen", 32'(hit), 32'd1);
    rst_n = 1'b0;
    chk_en = 0;
    cq.delete();
    rq.delete();
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_rvalid_y", bus.rvalid_y, 1'b0);
      chk("mid_rst_gnt_y", bus.gnt_y, 1'b0);
`ifdef MAP_ARB_STATS_EN
      chk("mid_rst_cnt_y", cnt_y, 16'h0);
`endif
    end
    rst_n = 1'b1;
    reset_model();
    chk_en = 1;
    run(1, 400);

    bus.req_x = 1'b0; bus.req_y = 1'b0; bus.vid_active = 1'b0;
    for (int i = 0; i < ROM_LAT + 3; i++) begin
      model_step();
      @(negedge clk);
    end
`ifdef MAP_ARB_STATS_EN
    chk("cnt_x", cnt_x, 32'(cntx));
    chk("cnt_y", cnt_y, 32'(cnty));
    chk("max_wait", max_wait, 32'(maxw));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
